// File: rtl/alu_cmd_issuer_if.sv
// Host command, ALU instruction and host response signals of the ALU command issuer.
// master is the issuer side; slave is the host/ALU side.
interface alu_cmd_issuer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [17:0] instr;
    logic        start;
    logic [7:0]  alu_result1;
    logic [7:0]  alu_result2;
    logic        alu_carry;
    logic        alu_overflow;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_op;
    logic [15:0] rsp_data;
    logic        rsp_carry;
    logic        rsp_overflow;
    logic        busy;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b,
        input  alu_result1, alu_result2, alu_carry, alu_overflow,
        input  rsp_ready,
        output cmd_ready, instr, start,
        output rsp_valid, rsp_op, rsp_data, rsp_carry, rsp_overflow, busy
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b,
        output alu_result1, alu_result2, alu_carry, alu_overflow,
        output rsp_ready,
        input  cmd_ready, instr, start,
        input  rsp_valid, rsp_op, rsp_data, rsp_carry, rsp_overflow, busy
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Initiator for the 8-bit ALU: queues host commands, issues them one at a time,
// waits a fixed per-op latency, and returns captured results on a valid/ready port.
module alu_cmd_issuer #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned MUL_LATENCY  = 8,
    parameter int unsigned COMB_LATENCY = 1
) (
    input logic              clk,
    input logic              rst,
    alu_cmd_issuer_if.master bus
);
    localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned MaxLat = (MUL_LATENCY > COMB_LATENCY) ? MUL_LATENCY : COMB_LATENCY;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    localparam logic [PtrW:0]   FullCount = FIFO_DEPTH[PtrW:0];
    localparam logic [PtrW:0]   CountOne  = 1;
    localparam logic [PtrW-1:0] PtrOne    = 1;
    localparam logic [CntW-1:0] MulCnt    = MUL_LATENCY[CntW-1:0];
    localparam logic [CntW-1:0] CombCnt   = COMB_LATENCY[CntW-1:0];
    localparam logic [CntW-1:0] CntOne    = 1;
    localparam logic [1:0]      OpAdd     = 2'b00;
    localparam logic [1:0]      OpMul     = 2'b11;

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StCapture, StResp} state_e;

    logic [17:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [PtrW:0]   count_q;
    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [17:0]     instr_q;
    logic            start_q;
    logic            rsp_valid_q;
    logic [1:0]      rsp_op_q;
    logic [15:0]     rsp_data_q;
    logic            rsp_carry_q;
    logic            rsp_overflow_q;

    logic fifo_full, fifo_empty, push, pop;

    assign fifo_full  = (count_q == FullCount);
    assign fifo_empty = (count_q == '0);
    // Readiness depends only on full, so a same-cycle pop never admits a push when full.
    assign push       = bus.cmd_valid && !fifo_full;
    assign pop        = (state_q == StIdle) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            count_q        <= '0;
            state_q        <= StIdle;
            cnt_q          <= '0;
            instr_q        <= '0;
            start_q        <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_op_q       <= '0;
            rsp_data_q     <= '0;
            rsp_carry_q    <= 1'b0;
            rsp_overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PtrOne;
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrOne;
            end
            if (push && !pop) begin
                count_q <= count_q + CountOne;
            end else if (!push && pop) begin
                count_q <= count_q - CountOne;
            end

            start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        instr_q <= mem_q[rptr_q];
                        // Registered so the pulse coincides exactly with the ISSUE cycle.
                        start_q <= (mem_q[rptr_q][17:16] == OpMul);
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    cnt_q   <= (instr_q[17:16] == OpMul) ? MulCnt : CombCnt;
                    state_q <= StWait;
                end
                StWait: begin
                    if (cnt_q == CntOne) begin
                        state_q <= StCapture;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
                StCapture: begin
                    rsp_valid_q    <= 1'b1;
                    rsp_op_q       <= instr_q[17:16];
                    rsp_data_q     <= {bus.alu_result1, bus.alu_result2};
                    rsp_carry_q    <= (instr_q[17:16] == OpAdd) && bus.alu_carry;
                    rsp_overflow_q <= (instr_q[17:16] == OpAdd) && bus.alu_overflow;
                    state_q        <= StResp;
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cmd_ready    = !fifo_full;
    assign bus.instr        = instr_q;
    assign bus.start        = start_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_op       = rsp_op_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_carry    = rsp_carry_q;
    assign bus.rsp_overflow = rsp_overflow_q;
    assign bus.busy         = (state_q != StIdle) || !fifo_empty;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: directed commands against a response scoreboard built
// from plain arithmetic, with a per-cycle protocol checker and literal pins.
module tb_alu_cmd_issuer;
    localparam int MulLat  = 8;
    localparam int CombLat = 1;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] data;
        logic        c;
        logic        v;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    alu_cmd_issuer_if bus ();

    alu_cmd_issuer #(
        .FIFO_DEPTH  (4),
        .MUL_LATENCY (MulLat),
        .COMB_LATENCY(CombLat)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in ALU; carry/overflow are deliberately set on non-add ops.
    logic [7:0]  alu_a, alu_b, r1, r2;
    logic        rc, rv;
    logic [8:0]  s9;
    logic [15:0] p16;
    always_comb begin
        alu_a = bus.instr[15:8];
        alu_b = bus.instr[7:0];
        s9    = {1'b0, alu_a} + {1'b0, alu_b};
        p16   = {8'h00, alu_a} * {8'h00, alu_b};
        r1    = 8'h00;
        r2    = 8'h00;
        rc    = 1'b1;
        rv    = 1'b1;
        case (bus.instr[17:16])
            2'b00: begin
                r2 = s9[7:0];
                rc = s9[8];
                rv = (alu_a[7] == alu_b[7]) && (s9[7] != alu_a[7]);
            end
            2'b01: r2 = alu_a & alu_b;
            2'b10: r2 = alu_a ^ alu_b;
            default: begin
                r1 = p16[15:8];
                r2 = p16[7:0];
            end
        endcase
    end
    assign bus.alu_result1  = r1;
    assign bus.alu_result2  = r2;
    assign bus.alu_carry    = rc;
    assign bus.alu_overflow = rv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    function automatic rsp_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        rsp_t r;
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        r.op = op;
        r.c  = 1'b0;
        r.v  = 1'b0;
        case (op)
            2'b00: begin
                r.data = 16'((ua + ub) % 256);
                r.c    = (ua + ub) > 255;
                r.v    = ((sa + sb) > 127) || ((sa + sb) < -128);
            end
            2'b01:   r.data = 16'(ua & ub);
            2'b10:   r.data = 16'(ua ^ ub);
            default: r.data = 16'(ua * ub);
        endcase
        return r;
    endfunction

    // Scoreboard and protocol checker, sampled on the falling edge.
    rsp_t        exp_q[$];
    int          n_rsp = 0;
    int          starts_seen = 0;
    int          last_push_edge = 0, last_start_edge = 0, last_rv_edge = 0;
    logic [15:0] last_data;
    logic        last_c, last_v;
    bit          have_prev = 0;
    logic        prev_valid, prev_ready, prev_start, prev_c, prev_v;
    logic [1:0]  prev_op;
    logic [15:0] prev_data;
    logic [17:0] prev_instr;

    always @(negedge clk) begin
        rsp_t e;
        if (rst) begin
            exp_q.delete();
            starts_seen = 0;
            have_prev   = 0;
        end else begin
            check("busy", 32'(bus.busy), 32'(exp_q.size() != 0));
            if (bus.start) begin
                check("start_op_is_mul", 32'(bus.instr[17:16]), 32'd3);
                if (have_prev) check("start_one_cycle", 32'(prev_start), 32'd0);
                starts_seen++;
                last_start_edge = cyc + 1;
            end
            if (have_prev && prev_valid && !prev_ready) begin
                check("hold_valid", 32'(bus.rsp_valid), 32'd1);
                check("hold_op", 32'(bus.rsp_op), 32'(prev_op));
                check("hold_data", 32'(bus.rsp_data), 32'(prev_data));
                check("hold_carry", 32'(bus.rsp_carry), 32'(prev_c));
                check("hold_ovf", 32'(bus.rsp_overflow), 32'(prev_v));
                check("hold_instr", 32'(bus.instr), 32'(prev_instr));
                check("hold_no_start", 32'(bus.start), 32'd0);
            end
            if (bus.rsp_valid && !(have_prev && prev_valid)) last_rv_edge = cyc + 1;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_rsp");
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_op", 32'(bus.rsp_op), 32'(e.op));
                    check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                    check("rsp_carry", 32'(bus.rsp_carry), 32'(e.c));
                    check("rsp_ovf", 32'(bus.rsp_overflow), 32'(e.v));
                    check("starts_per_cmd", 32'(starts_seen), 32'(e.op == 2'b11));
                end
                starts_seen = 0;
                last_data   = bus.rsp_data;
                last_c      = bus.rsp_carry;
                last_v      = bus.rsp_overflow;
                n_rsp++;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                exp_q.push_back(model(bus.cmd_op, bus.cmd_a, bus.cmd_b));
                last_push_edge = cyc + 1;
            end
            prev_valid = bus.rsp_valid;
            prev_ready = bus.rsp_ready;
            prev_start = bus.start;
            prev_op    = bus.rsp_op;
            prev_data  = bus.rsp_data;
            prev_c     = bus.rsp_carry;
            prev_v     = bus.rsp_overflow;
            prev_instr = bus.instr;
            have_prev  = 1;
        end
    end

    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int bound, output bit ok);
        ok            = 0;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) ok = 1;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int bound);
        bit done = 0;
        for (int i = 0; i < bound && !done; i++) begin
            @(posedge clk);
            #1;
            if (n_rsp >= target) done = 1;
        end
        if (!done) fail_now("wait_rsp");
    endtask

    task automatic wait_idle(input int bound);
        bit done = 0;
        for (int i = 0; i < bound && !done; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !bus.busy) done = 1;
        end
        if (!done) fail_now("wait_idle");
    endtask

    // Single command on an idle issuer, with literal result and latency pins.
    task automatic one(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] edata, input logic ec, input logic ev, input int lat);
        bit ok;
        int t;
        int base = n_rsp;
        send(op, a, b, 8, ok);
        check("one_accept", 32'(ok), 32'd1);
        t = last_push_edge;
        wait_rsp(base + 1, lat + 20);
        check("lit_data", 32'(last_data), 32'(edata));
        check("lit_carry", 32'(last_c), 32'(ec));
        check("lit_ovf", 32'(last_v), 32'(ev));
        check("rsp_latency", 32'(last_rv_edge), 32'(t + 4 + lat));
        if (op == 2'b11) check("start_edge", 32'(last_start_edge), 32'(t + 2));
    endtask

    initial begin
        bit ok;
        int base;
        logic [1:0] f_op [6];
        logic [7:0] f_a  [6];
        logic [7:0] f_b  [6];
        f_op = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 2'b11};
        f_a  = '{8'h10, 8'h03, 8'hAA, 8'h3C, 8'h90, 8'hFF};
        f_b  = '{8'h20, 8'h05, 8'h0F, 8'hC3, 8'h90, 8'hFF};

        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_a     = 8'h00;
        bus.cmd_b     = 8'h00;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_instr", 32'(bus.instr), 32'd0);
        check("rst_start", 32'(bus.start), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_op", 32'(bus.rsp_op), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_rsp_carry", 32'(bus.rsp_carry), 32'd0);
        check("rst_rsp_ovf", 32'(bus.rsp_overflow), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;

        one(2'b00, 8'h7F, 8'h01, 16'h0080, 1'b0, 1'b1, CombLat);
        one(2'b00, 8'hFF, 8'h01, 16'h0000, 1'b1, 1'b0, CombLat);
        one(2'b01, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0, CombLat);
        one(2'b10, 8'hFF, 8'h0F, 16'h00F0, 1'b0, 1'b0, CombLat);
        one(2'b11, 8'h0F, 8'h0F, 16'h00E1, 1'b0, 1'b0, MulLat);
        one(2'b00, 8'h80, 8'h80, 16'h0000, 1'b1, 1'b1, CombLat);

        // Fill: one in flight plus four queued while the host stalls responses.
        bus.rsp_ready = 1'b0;
        base = n_rsp;
        for (int i = 0; i < 5; i++) begin
            send(f_op[i], f_a[i], f_b[i], 8, ok);
            check("fill_accept", 32'(ok), 32'd1);
        end
        @(negedge clk);
        check("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        send(f_op[5], f_a[5], f_b[5], 4, ok);
        check("sixth_refused", 32'(ok), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("stall_no_rsp", 32'(n_rsp), 32'(base));
        check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        bus.rsp_ready = 1'b1;
        wait_rsp(base + 5, 200);
        wait_idle(20);
        check("fill_rsp_count", 32'(n_rsp), 32'(base + 5));

        // Reset during a multiply WAIT with another command queued.
        base = n_rsp;
        send(2'b11, 8'h12, 8'h34, 8, ok);
        send(2'b00, 8'h05, 8'h06, 8, ok);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_instr", 32'(bus.instr), 32'd0);
        check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("mid_rst_no_rsp", 32'(n_rsp), 32'(base));

        one(2'b10, 8'hA5, 8'h5A, 16'h00FF, 1'b0, 1'b0, CombLat);
        one(2'b11, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, MulLat);
        wait_idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (compared=%0d)", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
